// File: rtl/dds_pkg.sv
// Shared DDS definitions: loader state encoding and waveform table-type names
// used by both the table loader and the synthesizer.
package dds_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_t;

   // Table-type names shared with the synthesizer's table select.
   localparam string TABLE_FULL    = "FULL";
   localparam string TABLE_HALF    = "HALF";
   localparam string TABLE_QUARTER = "QUARTER";

   // A load length is usable only if it covers 1..depth entries.
   function automatic logic len_legal(input int unsigned len, input int unsigned depth);
      return (len != 0) && (len <= depth);
   endfunction

endpackage

// File: rtl/wfm_table_loader.sv
// Streaming writer for the DDS waveform table. Takes a ready/valid sample
// stream and writes a contiguous, wrapping block of the table from a base
// address, tracking word count, checksum and length errors for software.
module wfm_table_loader
   import dds_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned OW    = 24,
   parameter int unsigned CW    = 32,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   length,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [OW-1:0] s_data,
   input  logic          s_last,
   output logic          wfm_wea,
   output logic [AW-1:0] wfm_waddr,
   output logic [OW-1:0] wfm_din,
   output logic          busy,
   output logic          done,
   output logic          err_short,
   output logic          err_long,
   output logic          err_len,
   output logic [CW-1:0] checksum,
   output logic [AW:0]   words_written
);

   loader_state_t state_q, state_d;

   logic [AW-1:0] base_q;
   logic [AW:0]   len_q;
   logic [AW:0]   count_q;
   logic [CW-1:0] csum_q;
   logic          err_short_q, err_long_q, err_len_q;
   logic          wea_q;
   logic [AW-1:0] waddr_q;
   logic [OW-1:0] din_q;

   logic start_ok;
   logic len_ok;
   logic accept;
   logic last_len;
   logic term;

   assign start_ok = (state_q == IDLE) && start;
   assign len_ok   = len_legal(32'(length), DEPTH);
   // s_ready is purely a function of state, so acceptance needs only s_valid.
   assign accept   = (state_q == LOAD) && s_valid;
   assign last_len = ((count_q + (AW+1)'(1)) == len_q);
   assign term     = accept && (last_len || s_last);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = len_ok ? LOAD : DONE;
            end
         end
         LOAD: begin
            if (term) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      s_ready = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: ;
         LOAD: begin
            s_ready = 1'b1;
            busy    = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Load parameters, progress tracking and registered table write port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q      <= '0;
         len_q       <= '0;
         count_q     <= '0;
         csum_q      <= '0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         err_len_q   <= 1'b0;
         wea_q       <= 1'b0;
         waddr_q     <= '0;
         din_q       <= '0;
      end else begin
         wea_q <= accept;
         if (start_ok) begin
            base_q      <= base_addr;
            len_q       <= length;
            count_q     <= '0;
            csum_q      <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            err_len_q   <= !len_ok;
         end
         if (accept) begin
            // AW-bit sum truncates, giving the wrap-around at DEPTH.
            waddr_q <= base_q + count_q[AW-1:0];
            din_q   <= s_data;
            count_q <= count_q + (AW+1)'(1);
            csum_q  <= csum_q + CW'(s_data);
            if (term) begin
               err_short_q <= s_last && !last_len;
               err_long_q  <= last_len && !s_last;
            end
         end
      end
   end

   assign wfm_wea       = wea_q;
   assign wfm_waddr     = waddr_q;
   assign wfm_din       = din_q;
   assign err_short     = err_short_q;
   assign err_long      = err_long_q;
   assign err_len       = err_len_q;
   assign checksum      = csum_q;
   assign words_written = count_q;

endmodule
